// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared constants and saturating add for the systolic PE
package sa_pkg;

  // Runtime dataflow mode
  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Shadow weight buffer state encoding
  localparam logic [0:0] WB_EMPTY = 1'b0;
  localparam logic [0:0] WB_FULL  = 1'b1;

  // Default datapath widths
  localparam int SA_A_W = 8;
  localparam int SA_W_W = 8;
  localparam int SA_P_W = 24;

  // Wide working width for the accumulate path; any P_W up to 63 fits with headroom,
  // so the exact sum of two P_W-range values never overflows here.
  localparam int SA_WIDE_W = 64;
  typedef logic signed [SA_WIDE_W-1:0] sa_wide_t;

  // Adds two values already in P_W range and fits the exact sum back into pw bits:
  // clamp to the signed pw range when sat is set, otherwise two's-complement wrap.
  // The fitted result differs from the exact sum exactly when the sum was out of range.
  function automatic sa_wide_t sat_add(input sa_wide_t a, input sa_wide_t b,
                                       input int pw, input bit sat);
    sa_wide_t sum;
    sa_wide_t hi;
    sa_wide_t lo;
    sa_wide_t res;
    sum = a + b;
    hi  = (sa_wide_t'(1) <<< (pw - 1)) - sa_wide_t'(1);
    lo  = ~hi;
    if (sat) begin
      if (sum > hi)      res = hi;
      else if (sum < lo) res = lo;
      else               res = sum;
    end else begin
      res = (sum <<< (SA_WIDE_W - pw)) >>> (SA_WIDE_W - pw);
    end
    return res;
  endfunction

endpackage

// File: rtl/sa_pe_wbuf.sv
// rtl/sa_pe_wbuf.sv - shadow/active weight double buffer with EMPTY/FULL tracking
module sa_pe_wbuf
  import sa_pkg::*;
#(
  parameter int W_W = SA_W_W
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  w_load_i,
  input  logic signed [W_W-1:0] w_in_i,
  input  logic                  w_swap_i,
  output logic signed [W_W-1:0] w_act_o,
  output logic                  w_full_o,
  output logic                  swap_err_o
);

  logic [0:0]            state_q, state_d;
  logic signed [W_W-1:0] w_act_q, w_act_d;
  logic signed [W_W-1:0] w_shd_q, w_shd_d;
  logic                  swap_err_q, swap_err_d;
  logic                  swap_ok;

  assign swap_ok = w_swap_i && (state_q == WB_FULL);

  // Next state: a swap commits only when the shadow holds data; a load always (re)fills
  // the shadow, so load+swap in FULL moves the old shadow to active and stays FULL.
  always_comb begin
    state_d    = state_q;
    w_act_d    = w_act_q;
    w_shd_d    = w_shd_q;
    swap_err_d = w_swap_i && (state_q == WB_EMPTY);
    if (swap_ok) begin
      w_act_d = w_shd_q;
      state_d = WB_EMPTY;
    end
    if (w_load_i) begin
      w_shd_d = w_in_i;
      state_d = WB_FULL;
    end
  end

  // Buffer registers; reset drops any pending shadow weight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= WB_EMPTY;
      w_act_q    <= '0;
      w_shd_q    <= '0;
      swap_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_act_q    <= w_act_d;
      w_shd_q    <= w_shd_d;
      swap_err_q <= swap_err_d;
    end
  end

  assign w_act_o    = w_act_q;
  assign w_full_o   = (state_q == WB_FULL);
  assign swap_err_o = swap_err_q;

endmodule

// File: rtl/sa_pe_dbuf.sv
// rtl/sa_pe_dbuf.sv - systolic PE with double-buffered weights, WS/OS modes and saturating MAC
module sa_pe_dbuf
  import sa_pkg::*;
#(
  parameter int A_W = SA_A_W,
  parameter int W_W = SA_W_W,
  parameter int P_W = SA_P_W,
  parameter int SAT = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  MODE,
  input  logic                  W_LOAD,
  input  logic signed [W_W-1:0] W_IN,
  input  logic                  W_SWAP,
  input  logic                  EN_L,
  input  logic                  EN_T,
  output logic                  EN_R,
  output logic                  EN_D,
  input  logic signed [A_W-1:0] A_IN,
  output logic signed [A_W-1:0] A_OUT,
  input  logic signed [W_W-1:0] B_IN,
  output logic signed [W_W-1:0] B_OUT,
  input  logic signed [P_W-1:0] PSUM_IN,
  output logic signed [P_W-1:0] PSUM_OUT,
  input  logic                  ACC_CLR,
  input  logic                  DRAIN,
  output logic                  W_FULL,
  output logic                  SWAP_ERR,
  output logic                  OVF
);

  logic signed [W_W-1:0]     w_act;
  logic signed [W_W-1:0]     op;
  logic signed [A_W+W_W-1:0] prod;
  sa_wide_t                  prod_w, base_w, sum_w, fit_w;
  logic signed [P_W-1:0]     mac_res;
  logic                      mac_fire, fwd_en, os_mode, drain_os, out_of_range;

  logic signed [A_W-1:0]     a_q;
  logic signed [W_W-1:0]     b_q;
  logic                      en_r_q, en_d_q;
  logic signed [P_W-1:0]     psum_q, psum_d;
  logic signed [P_W-1:0]     acc_q, acc_d;
  logic                      ovf_q, ovf_d;

  sa_pe_wbuf #(
    .W_W (W_W)
  ) u_wbuf (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .w_load_i   (W_LOAD),
    .w_in_i     (W_IN),
    .w_swap_i   (W_SWAP),
    .w_act_o    (w_act),
    .w_full_o   (W_FULL),
    .swap_err_o (SWAP_ERR)
  );

  assign os_mode  = (MODE == MODE_OS);
  assign mac_fire = EN_L && EN_T;
  assign fwd_en   = EN_L || EN_T;
  assign drain_os = DRAIN && os_mode;

  // Multiplier operand: stationary weight in WS, streamed B in OS.
  assign op = os_mode ? B_IN : w_act;

  // Sign-extend both operands to the full product width so the low bits of the
  // unsigned multiply are the exact signed product.
  assign prod = $signed({{W_W{A_IN[A_W-1]}}, A_IN} * {{A_W{op[W_W-1]}}, op});

  // One adder serves both modes: WS adds the incoming partial sum, OS the local accumulator.
  assign prod_w       = sa_wide_t'(prod);
  assign base_w       = os_mode ? sa_wide_t'(acc_q) : sa_wide_t'(PSUM_IN);
  assign sum_w        = base_w + prod_w;
  assign fit_w        = sat_add(base_w, prod_w, P_W, SAT != 0);
  assign out_of_range = (fit_w != sum_w);
  assign mac_res      = $signed(fit_w[P_W-1:0]);

  // Result/accumulator next state. A drain that coincides with a MAC emits the updated
  // sum so the product is not lost; ACC_CLR wins over any accumulator update but never
  // touches PSUM_OUT.
  always_comb begin
    psum_d = psum_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (drain_os) begin
      psum_d = mac_fire ? mac_res : acc_q;
    end else if (mac_fire && !os_mode) begin
      psum_d = mac_res;
    end
    if (ACC_CLR || drain_os) begin
      acc_d = '0;
    end else if (mac_fire && os_mode) begin
      acc_d = mac_res;
    end
    if (ACC_CLR) begin
      ovf_d = 1'b0;
    end else if (mac_fire && out_of_range) begin
      ovf_d = 1'b1;
    end
  end

  // Neighbour forwarding registers; they hold whenever neither enable is present.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      a_q    <= '0;
      b_q    <= '0;
      en_r_q <= 1'b0;
      en_d_q <= 1'b0;
    end else if (fwd_en) begin
      a_q    <= A_IN;
      b_q    <= B_IN;
      en_r_q <= EN_L;
      en_d_q <= EN_T;
    end
  end

  // Partial-sum output, OS accumulator and sticky overflow flag.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      psum_q <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      psum_q <= psum_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign A_OUT    = a_q;
  assign B_OUT    = b_q;
  assign EN_R     = en_r_q;
  assign EN_D     = en_d_q;
  assign PSUM_OUT = psum_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_sa_pe_dbuf.sv
// tb/tb_sa_pe_dbuf.sv - self-checking bench for sa_pe_dbuf (P_W=24 sat, P_W=16 sat, P_W=16 wrap)
module tb_sa_pe_dbuf;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              rstn, mode, w_load, w_swap, en_l, en_t, acc_clr, drain;
  logic signed [7:0] w_in, a_in, b_in;
  logic signed [23:0] psum_in;

  logic              en_r_o [3];
  logic              en_d_o [3];
  logic signed [7:0] a_out_o [3];
  logic signed [7:0] b_out_o [3];
  logic              wfull_o [3];
  logic              serr_o [3];
  logic              ovf_o [3];
  logic signed [23:0] psum24;
  logic signed [15:0] psum16s, psum16w;

  sa_pe_dbuf #(.A_W(8), .W_W(8), .P_W(24), .SAT(1)) u24 (
    .CLK(CLK), .RSTN(rstn), .MODE(mode), .W_LOAD(w_load), .W_IN(w_in), .W_SWAP(w_swap),
    .EN_L(en_l), .EN_T(en_t), .EN_R(en_r_o[0]), .EN_D(en_d_o[0]),
    .A_IN(a_in), .A_OUT(a_out_o[0]), .B_IN(b_in), .B_OUT(b_out_o[0]),
    .PSUM_IN(psum_in), .PSUM_OUT(psum24), .ACC_CLR(acc_clr), .DRAIN(drain),
    .W_FULL(wfull_o[0]), .SWAP_ERR(serr_o[0]), .OVF(ovf_o[0]));

  sa_pe_dbuf #(.A_W(8), .W_W(8), .P_W(16), .SAT(1)) u16s (
    .CLK(CLK), .RSTN(rstn), .MODE(mode), .W_LOAD(w_load), .W_IN(w_in), .W_SWAP(w_swap),
    .EN_L(en_l), .EN_T(en_t), .EN_R(en_r_o[1]), .EN_D(en_d_o[1]),
    .A_IN(a_in), .A_OUT(a_out_o[1]), .B_IN(b_in), .B_OUT(b_out_o[1]),
    .PSUM_IN(psum_in[15:0]), .PSUM_OUT(psum16s), .ACC_CLR(acc_clr), .DRAIN(drain),
    .W_FULL(wfull_o[1]), .SWAP_ERR(serr_o[1]), .OVF(ovf_o[1]));

  sa_pe_dbuf #(.A_W(8), .W_W(8), .P_W(16), .SAT(0)) u16w (
    .CLK(CLK), .RSTN(rstn), .MODE(mode), .W_LOAD(w_load), .W_IN(w_in), .W_SWAP(w_swap),
    .EN_L(en_l), .EN_T(en_t), .EN_R(en_r_o[2]), .EN_D(en_d_o[2]),
    .A_IN(a_in), .A_OUT(a_out_o[2]), .B_IN(b_in), .B_OUT(b_out_o[2]),
    .PSUM_IN(psum_in[15:0]), .PSUM_OUT(psum16w), .ACC_CLR(acc_clr), .DRAIN(drain),
    .W_FULL(wfull_o[2]), .SWAP_ERR(serr_o[2]), .OVF(ovf_o[2]));

  int checks = 0;
  int failures = 0;

  // Reference model: one set of architectural values per instance, as plain integers.
  int     CFG_PW  [3] = '{24, 16, 16};
  bit     CFG_SAT [3] = '{1'b1, 1'b1, 1'b0};
  longint m_wact [3], m_wshd [3], m_acc [3], m_psum [3], m_aout [3], m_bout [3];
  bit     m_full [3], m_serr [3], m_ovf [3], m_enr [3], m_end [3];

  function automatic longint range_hi(input int pw);
    return (longint'(1) << (pw - 1)) - 1;
  endfunction

  // Bring an exact integer into the pw-bit signed range by clamping or wrapping.
  function automatic longint fitv(input longint s, input int pw, input bit sat);
    longint hi, lo, m, r;
    hi = range_hi(pw);
    lo = -hi - 1;
    if (s >= lo && s <= hi) return s;
    if (sat) return (s > hi) ? hi : lo;
    m = longint'(1) << pw;
    r = s % m;
    if (r < 0) r = r + m;
    if (r > hi) r = r - m;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_wact[k] = 0; m_wshd[k] = 0; m_acc[k] = 0; m_psum[k] = 0;
      m_aout[k] = 0; m_bout[k] = 0;
      m_full[k] = 0; m_serr[k] = 0; m_ovf[k] = 0; m_enr[k] = 0; m_end[k] = 0;
    end
  endtask

  task automatic model_step();
    bit     fire, fwd, os, drn, oor;
    longint op, base, exact, fv, hi;
    if (!rstn) begin
      model_reset();
      return;
    end
    fire = en_l && en_t;
    fwd  = en_l || en_t;
    os   = mode;
    drn  = os && drain;
    for (int k = 0; k < 3; k++) begin
      hi    = range_hi(CFG_PW[k]);
      op    = os ? longint'(b_in) : m_wact[k];
      base  = os ? m_acc[k] : fitv(longint'(psum_in), CFG_PW[k], 1'b0);
      exact = base + longint'(a_in) * op;
      fv    = fitv(exact, CFG_PW[k], CFG_SAT[k]);
      oor   = (exact > hi) || (exact < -hi - 1);
      if (drn) m_psum[k] = fire ? fv : m_acc[k];
      else if (fire && !os) m_psum[k] = fv;
      if (acc_clr || drn) m_acc[k] = 0;
      else if (fire && os) m_acc[k] = fv;
      if (acc_clr) m_ovf[k] = 0;
      else if (fire && oor) m_ovf[k] = 1;
      m_serr[k] = w_swap && !m_full[k];
      if (w_swap && m_full[k]) begin
        m_wact[k] = m_wshd[k];
        m_full[k] = 0;
      end
      if (w_load) begin
        m_wshd[k] = longint'(w_in);
        m_full[k] = 1;
      end
      if (fwd) begin
        m_aout[k] = longint'(a_in);
        m_bout[k] = longint'(b_in);
        m_enr[k]  = en_l;
        m_end[k]  = en_t;
      end
    end
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    longint ps;
    for (int k = 0; k < 3; k++) begin
      ps = (k == 0) ? longint'(psum24) : (k == 1) ? longint'(psum16s) : longint'(psum16w);
      chk($sformatf("%s.psum%0d", tag, k),  ps,                  m_psum[k]);
      chk($sformatf("%s.aout%0d", tag, k),  longint'(a_out_o[k]), m_aout[k]);
      chk($sformatf("%s.bout%0d", tag, k),  longint'(b_out_o[k]), m_bout[k]);
      chk($sformatf("%s.enr%0d", tag, k),   longint'(en_r_o[k]),  longint'(m_enr[k]));
      chk($sformatf("%s.end%0d", tag, k),   longint'(en_d_o[k]),  longint'(m_end[k]));
      chk($sformatf("%s.wfull%0d", tag, k), longint'(wfull_o[k]), longint'(m_full[k]));
      chk($sformatf("%s.serr%0d", tag, k),  longint'(serr_o[k]),  longint'(m_serr[k]));
      chk($sformatf("%s.ovf%0d", tag, k),   longint'(ovf_o[k]),   longint'(m_ovf[k]));
    end
  endtask

  task automatic idle();
    w_load = 0; w_swap = 0; en_l = 0; en_t = 0; acc_clr = 0; drain = 0;
  endtask

  task automatic cyc(input string tag);
    @(posedge CLK);
    model_step();
    #1;
    compare_all(tag);
  endtask

  initial begin
    rstn = 0; mode = 0; w_in = 0; a_in = 0; b_in = 0; psum_in = 0;
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1 compare_all("reset");
    @(negedge CLK) rstn = 1;

    // WS basic: weight 3, A=-4, PSUM_IN=100 -> 88
    w_load = 1; w_in = 3; cyc("ws_load");
    idle(); w_swap = 1; cyc("ws_swap");
    idle(); en_l = 1; en_t = 1; a_in = -4; psum_in = 100; cyc("ws_mac");
    chk("ws_psum88", longint'(psum24), 88);
    chk("ws_enr", longint'(en_r_o[0]), 1);
    chk("ws_end", longint'(en_d_o[0]), 1);

    // Double buffer: load 5 while MACs keep using 3
    w_load = 1; w_in = 5; a_in = 2; psum_in = 0; cyc("db_load");
    chk("db_uses_old", longint'(psum24), 6);
    chk("db_wfull", longint'(wfull_o[0]), 1);
    w_load = 0; cyc("db_mac_old");
    idle(); w_swap = 1; cyc("db_swap");
    chk("db_wfull_clr", longint'(wfull_o[0]), 0);
    idle(); en_l = 1; en_t = 1; cyc("db_mac_new");
    chk("db_uses_new", longint'(psum24), 10);

    // Swap with empty shadow, then load+swap in FULL
    idle(); w_swap = 1; cyc("se_swap");
    chk("se_pulse", longint'(serr_o[0]), 1);
    idle(); cyc("se_idle");
    chk("se_pulse_end", longint'(serr_o[0]), 0);
    w_load = 1; w_in = 7; cyc("ls_load7");
    w_load = 1; w_in = 9; w_swap = 1; cyc("ls_both");
    chk("ls_wfull", longint'(wfull_o[0]), 1);
    idle(); en_l = 1; en_t = 1; a_in = 1; psum_in = 0; cyc("ls_mac");
    chk("ls_active7", longint'(psum24), 7);

    // OS: 4 MACs of 2*3, drain 24, drain again 0
    idle(); mode = 1; cyc("os_mode");
    acc_clr = 1; cyc("os_clr");
    idle(); en_l = 1; en_t = 1; a_in = 2; b_in = 3;
    repeat (4) cyc("os_mac");
    idle(); drain = 1; cyc("os_drain1");
    chk("os_drain24", longint'(psum24), 24);
    cyc("os_drain2");
    chk("os_drain0", longint'(psum24), 0);

    // Saturation / wrap: 32000 + 127*127
    idle(); mode = 0; cyc("sat_mode");
    w_load = 1; w_in = 127; cyc("sat_load");
    idle(); w_swap = 1; cyc("sat_swap");
    idle(); en_l = 1; en_t = 1; a_in = 127; psum_in = 32000; cyc("sat_mac");
    chk("sat_clamp", longint'(psum16s), 32767);
    chk("sat_wrap", longint'(psum16w), -17407);
    chk("sat_wide", longint'(psum24), 48129);
    chk("sat_ovf_s", longint'(ovf_o[1]), 1);
    chk("sat_ovf_w", longint'(ovf_o[2]), 1);
    idle(); cyc("sat_hold");
    chk("sat_sticky", longint'(ovf_o[1]), 1);
    acc_clr = 1; cyc("sat_clr");
    chk("sat_ovf_cleared", longint'(ovf_o[1]), 0);

    // Single enable: forward only, PSUM_OUT holds
    idle(); en_l = 1; a_in = 55; psum_in = 1234; cyc("fwd_only");
    chk("fwd_aout", longint'(a_out_o[0]), 55);
    chk("fwd_psum_hold", longint'(psum24), 48129);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en_l    = ($urandom_range(0, 9) < 6);
      en_t    = ($urandom_range(0, 9) < 6);
      if (!en_l && !en_t && $urandom_range(0, 9) == 0) mode = ~mode;
      w_load  = ($urandom_range(0, 9) < 3);
      w_swap  = ($urandom_range(0, 9) < 3);
      w_in    = 8'($urandom);
      a_in    = 8'($urandom);
      b_in    = 8'($urandom);
      psum_in = ($urandom_range(0, 3) == 0) ? 24'($urandom)
                                             : 24'($urandom_range(0, 4000)) - 24'd2000;
      acc_clr = ($urandom_range(0, 19) == 0);
      drain   = ($urandom_range(0, 9) == 0);
      cyc("rnd");
    end

    // Asynchronous reset while accumulating in OS
    idle(); mode = 1; cyc("ar_mode");
    en_l = 1; en_t = 1; a_in = 5; b_in = 7;
    repeat (3) cyc("ar_mac");
    #2 rstn = 0;
    #1 model_reset();
    compare_all("ar_async");
    chk("ar_psum0", longint'(psum24), 0);
    chk("ar_enr0", longint'(en_r_o[0]), 0);
    idle();
    @(negedge CLK) rstn = 1;
    cyc("ar_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
